// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   tx_state_t  : transmit frame sequencer states
//   PARITY_EVEN : parity-mode constant, parity bit = ^data
//   PARITY_ODD  : parity-mode constant, parity bit = ~^data
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   restart  : forces the count back to 0 on the next edge (frame start)
//   bit_tick : one-cycle pulse on the last cycle of every bit period
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: one-deep holding register feeding a frame
// serialiser (start, DATA_BITS LSB first, optional parity, stop bits).
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   Tx_Data    : word to transmit
//   Load_Data  : write strobe, accepted only while Tx_Ready=1
//   BIST_Mode  : blocks new loads and new frame starts
//   Tx_Serial  : registered serial line, idle high
//   Tx_Ready   : holding register empty and BIST_Mode=0
//   Tx_Busy    : frame in progress
//   Tx_Done    : one-cycle pulse after the last stop bit
//   Tx_Overrun : sticky, load attempted while not ready (outside BIST)
module uart_tx
  import uart_pkg::tx_state_t, uart_pkg::IDLE, uart_pkg::START,
         uart_pkg::DATA, uart_pkg::PARITY, uart_pkg::STOP;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Load_Data,
  input  logic                 BIST_Mode,
  output logic                 Tx_Serial,
  output logic                 Tx_Ready,
  output logic                 Tx_Busy,
  output logic                 Tx_Done,
  output logic                 Tx_Overrun
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic PAR_INV = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                               : uart_pkg::PARITY_EVEN;

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic bit_tick;
  logic restart;
  logic launch;
  logic load_ok;
  logic load_rej;
  logic start_ok;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  assign Tx_Ready = ~hold_full_q & ~BIST_Mode;
  assign load_ok  = Load_Data & Tx_Ready;
  assign load_rej = Load_Data & ~Tx_Ready & ~BIST_Mode;
  assign start_ok = hold_full_q & ~BIST_Mode;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    launch      = 1'b0;
    restart     = 1'b0;
    tx_d        = 1'b1;

    if (load_ok) begin
      hold_d      = Tx_Data;
      hold_full_d = 1'b1;
      ovr_d       = 1'b0;
    end else if (load_rej) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) launch = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (start_ok) launch = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start drains the holding register; parity is captured from the
    // whole word here because the shift register is consumed bit by bit.
    if (launch) begin
      state_d     = START;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ PAR_INV;
      hold_full_d = 1'b0;
      restart     = 1'b1;
    end

    // Line value is derived from the next state so Tx_Serial can be a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign Tx_Serial  = tx_q;
  assign Tx_Busy    = (state_q != IDLE);
  assign Tx_Done    = done_q;
  assign Tx_Overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: an even-parity and an odd-parity
// instance receive identical stimulus; per-instance monitors decode the
// line and compare each frame against words queued by the stimulus model.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned NBITS = 11;
  localparam longint      FRAME = 44;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic [7:0] Tx_Data   = 8'h00;
  logic       Load_Data = 1'b0;
  logic       BIST_Mode = 1'b0;

  logic [1:0] ser, rdy, busy, done, ovr;

  int n_checks = 0;
  int n_errs   = 0;
  longint edge_n = 0;

  // Scoreboard: every accepted word, in acceptance order.
  logic [7:0]  words [$];
  int unsigned idx [2];

  // Timing model of the holding register and line occupancy, in edge numbers.
  logic   m_held  = 1'b0;
  longint m_drain = 0;
  longint m_busy  = 0;
  logic   m_ovr   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst_n(rst_n), .Tx_Data(Tx_Data), .Load_Data(Load_Data), .BIST_Mode(BIST_Mode),
    .Tx_Serial(ser[0]), .Tx_Ready(rdy[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]), .Tx_Overrun(ovr[0]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .Tx_Data(Tx_Data), .Load_Data(Load_Data), .BIST_Mode(BIST_Mode),
    .Tx_Serial(ser[1]), .Tx_Ready(rdy[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]), .Tx_Overrun(ovr[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One frame, entered on its first start-bit sample. chained_in marks that
  // this sample is also the Tx_Done cycle of the previous frame.
  task automatic run_frame(input int p, input logic chained_in, output logic chained);
    logic [7:0]        w;
    logic [NBITS-1:0]  bits;
    int unsigned       ones;
    logic              bad;
    logic              exp_done;
    chained = 1'b0;
    n_checks++;
    if (idx[p] < words.size()) begin
      w = words[idx[p]];
      idx[p]++;
    end else begin
      w = 8'h00;
      n_errs++;
      $display("FAIL unexpected_frame dut%0d: got a start bit, expected no frame", p);
    end
    ones = $countones(w);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    bits[9]  = ((ones + p) % 2 == 1);
    bits[10] = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst_n) return;
        exp_done = chained_in && b == 0 && c == 0;
        if (ser[p] !== bits[b] || busy[p] !== 1'b1 || done[p] !== exp_done) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
        n_errs++;
        $display("FAIL frame_bit dut%0d word %h bit %0d: line %b busy %b done %b, required line %b busy 1 done 0",
                 p, w, b, ser[p], busy[p], done[p], bits[b]);
      end
    end
    @(negedge clk);
    if (!rst_n) return;
    chk($sformatf("done_pulse_dut%0d", p), {31'd0, done[p]}, 32'd1);
    chained = (ser[p] === 1'b0);
  endtask

  task automatic monitor(input int p);
    logic chained;
    logic nxt;
    chained = 1'b0;
    forever begin
      if (!chained) @(negedge clk);
      if (!rst_n) begin
        chained = 1'b0;
      end else if (ser[p] === 1'b0) begin
        run_frame(p, chained, nxt);
        chained = nxt;
      end else begin
        chained = 1'b0;
        chk($sformatf("idle_dut%0d", p), {30'd0, busy[p], done[p]}, 32'd0);
      end
    end
  endtask

  // Strobe one word at the current negedge; the model decides acceptance.
  task automatic do_load(input logic [7:0] d);
    longint e;
    longint st;
    logic   r;
    e = edge_n + 1;
    if (m_held && m_drain <= e - 1) m_held = 1'b0;
    r = !m_held;
    chk("ready_before_load", {30'd0, rdy}, r ? 32'd3 : 32'd0);
    Tx_Data   = d;
    Load_Data = 1'b1;
    if (r) begin
      st      = (e + 1 > m_busy) ? e + 1 : m_busy;
      m_held  = 1'b1;
      m_drain = st;
      m_busy  = st + FRAME;
      m_ovr   = 1'b0;
      words.push_back(d);
    end else begin
      m_ovr = 1'b1;
    end
    @(negedge clk);
    Load_Data = 1'b0;
    chk("overrun_after_load", {30'd0, ovr}, m_ovr ? 32'd3 : 32'd0);
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_busy = 0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    logic bad;
    idx[0] = 0;
    idx[1] = 0;
    fork
      monitor(0);
      monitor(1);
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle after reset.
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({ser, rdy, busy, done, ovr} !== 10'b11_11_00_00_00) bad = 1'b1;
    end
    chk("reset_idle_100", {31'd0, bad}, 32'd0);

    // Single word with start-bit latency.
    do_load(8'hA5);
    chk("ready_after_E0", {30'd0, rdy}, 32'd0);
    @(negedge clk);
    chk("start_latency", {26'd0, ser, busy, rdy}, 32'b00_11_11);
    repeat (60) @(negedge clk);

    // Back-to-back frames.
    do_load(8'h00);
    repeat (10) @(negedge clk);
    do_load(8'hFF);
    bad = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (busy !== 2'b11) bad = 1'b1;
    end
    chk("busy_back_to_back", {31'd0, bad}, 32'd0);
    repeat (30) @(negedge clk);

    // Three loads with one idle cycle between strobes.
    do_load(8'h11);
    @(negedge clk);
    do_load(8'h22);
    @(negedge clk);
    do_load(8'h33);
    repeat (100) @(negedge clk);
    do_load(8'h44);
    repeat (60) @(negedge clk);

    // Randomised loads and gaps.
    for (int i = 0; i < 25; i++) begin
      do_load(8'($urandom));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    repeat (120) @(negedge clk);

    // Reset during data bit 3.
    do_load(8'h3C);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {22'd0, ser, busy, rdy, done, ovr}, 32'b11_00_11_00_00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_load(8'h5A);
    repeat (60) @(negedge clk);

    // BIST raised mid-frame with one word held.
    do_load(8'hC3);
    repeat (5) @(negedge clk);
    do_load(8'h96);
    repeat (3) @(negedge clk);
    BIST_Mode = 1'b1;
    #1 chk("bist_ready_low", {30'd0, rdy}, 32'd0);
    @(negedge clk);
    Tx_Data   = 8'h77;
    Load_Data = 1'b1;
    @(negedge clk);
    Load_Data = 1'b0;
    chk("bist_load_no_overrun", {30'd0, ovr}, 32'd0);
    repeat (40) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({ser, busy, rdy} !== 6'b11_00_00) bad = 1'b1;
    end
    chk("bist_hold_idle", {31'd0, bad}, 32'd0);
    BIST_Mode = 1'b0;
    @(negedge clk);
    chk("bist_release_start", {28'd0, ser, busy}, 32'b00_11);
    repeat (60) @(negedge clk);

    chk("frames_dut0", idx[0], words.size());
    chk("frames_dut1", idx[1], words.size());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit engine: the transmit-direction counterpart of the receive FIFO. Accepts parallel words through a one-deep holding register and serialises each word as an asynchronous frame (start bit, data bits LSB first, optional parity bit, stop bits) on `Tx_Serial`. It sits between the transmit-side host logic and the line driver and shares `BIST_Mode` with the receive path.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame (5..9)
- `CLKS_PER_BIT`, 16, clock cycles per bit period (>= 2)
- `PARITY_EN`, 1, 1 = parity bit present
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity
- `STOP_BITS`, 1, stop bits per frame (1 or 2)

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `Tx_Data`  in  DATA_BITS  word to transmit
- `Load_Data`  in  1  write strobe; accepted only in a cycle where `Tx_Ready`=1
- `BIST_Mode`  in  1  1 = block new loads and new frame starts
- `Tx_Serial`  out  1  serial line, idle high
- `Tx_Ready`  out  1  holding register empty and `BIST_Mode`=0
- `Tx_Busy`  out  1  frame in progress
- `Tx_Done`  out  1  one-cycle pulse at end of each frame
- `Tx_Overrun`  out  1  sticky: a load was attempted while `Tx_Ready`=0 and `BIST_Mode`=0

## Operation
- Reset values: `Tx_Serial`=1, `Tx_Ready`=1 (when `BIST_Mode`=0), `Tx_Busy`=0, `Tx_Done`=0, `Tx_Overrun`=0, holding register empty, FSM IDLE.
- `Tx_Ready` = !hold_full && !`BIST_Mode` (combinational in `BIST_Mode`).
- Load accepted: `Tx_Data` is captured into the holding register and hold_full is set. Accepting a load clears `Tx_Overrun`.
- Load rejected (`Load_Data`=1, `Tx_Ready`=0, `BIST_Mode`=0): data is dropped and `Tx_Overrun` is set. A load while `BIST_Mode`=1 is dropped without setting overrun.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when hold_full && !`BIST_Mode`. The holding register moves to the shift register and hold_full clears on the same edge.
  - START -> DATA after one bit period.
  - DATA -> PARITY after `DATA_BITS` bit periods (or -> STOP if `PARITY_EN`=0).
  - PARITY -> STOP after one bit period.
  - STOP lasts `STOP_BITS` bit periods, then goes to START if hold_full && !`BIST_Mode`, otherwise to IDLE.
- Line values: START drives 0. DATA drives shift[0] and shifts right at each bit boundary. PARITY drives ^data for even parity or ~^data for odd parity. STOP drives 1.
- `Tx_Busy` = state != IDLE. `BIST_Mode` never aborts a frame in progress. The holding register keeps its contents while `BIST_Mode`=1.
- Baud counter: width $clog2(`CLKS_PER_BIT`). It restarts at 0 on every IDLE->START or STOP->START transition and wraps at `CLKS_PER_BIT`-1, which marks a bit boundary.
- Bit counter: width $clog2(`DATA_BITS`+1).
- `Tx_Serial` is registered (glitch-free).

## Timing
- Load accepted at edge E0 -> `Tx_Ready`=0 after E0.
- From IDLE: edge E1 starts the frame. `Tx_Serial`=0 and `Tx_Busy`=1 after E1, and `Tx_Ready` returns to 1 after E1. Latency from strobe to start bit is 2 cycles.
- Frame length = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) x `CLKS_PER_BIT` cycles. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- `Tx_Done` is high for exactly the one cycle following the edge that ends the last stop bit.
- Back-to-back: if hold_full at the end of a frame, the next start bit begins on the same edge that raises `Tx_Done`. There are no idle cycles and `Tx_Busy` stays 1.
- Load in the same cycle the holding register drains: `Tx_Ready` was 0 in that cycle, so the load is rejected and `Tx_Overrun`=1.
- `rst_n` asserted mid-frame: all outputs take their reset values immediately (asynchronous) and the frame is aborted. The first frame after release is clean.

## Structure
- `uart_pkg`: `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and parity-mode constants `PARITY_EVEN`/`PARITY_ODD`, shared with the receive path.
- Sub-module `uart_baud_gen`:
  - Parameter `CLKS_PER_BIT`.
  - Inputs `clk`, `rst_n`, `restart`.
  - Output `bit_tick`, a one-cycle pulse at each bit boundary.
- `uart_tx` holds the holding register, the FSM, the shift register and the parity logic.

## Test plan
All scenarios use `DATA_BITS`=8, `CLKS_PER_BIT`=4, `STOP_BITS`=1, giving a 44-cycle frame.
- Reset with no stimulus -> `Tx_Serial`=1, `Tx_Ready`=1, `Tx_Busy`=0, `Tx_Done`=0 and `Tx_Overrun`=0 hold for 100 cycles.
- Load 0xA5 with even parity:
  - Line is 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1, each bit 4 cycles.
  - Start bit appears 2 cycles after the strobe.
  - `Tx_Done` pulses once, 44 cycles after the start bit begins.
- Odd parity, load 0x00 then 0xFF (second load during the first frame):
  - Parity bits are 1 then 1.
  - Second start bit immediately follows the first stop bit; `Tx_Busy` never drops.
- Three loads (0x11, 0x22, 0x33) one cycle apart from IDLE:
  - 0x33 is dropped and `Tx_Overrun`=1.
  - Only 0x11 and 0x22 are transmitted.
  - A later load of 0x44 clears `Tx_Overrun` and transmits.
- `rst_n` pulsed low during data bit 3 -> `Tx_Serial`=1 and `Tx_Busy`=0 immediately. Load 0x5A after release -> correct frame.
- Raise `BIST_Mode` mid-frame with one word held:
  - Current frame completes, then the line stays idle and `Tx_Ready`=0.
  - A load during BIST is ignored and `Tx_Overrun` stays 0.
  - Lowering `BIST_Mode` starts the held word's frame on the next edge.
